// File: rtl/sprite_compositor.sv
// Composites NUM_SPRITES rectangular sprites over the tile layer into a registered 2-stage VGA pixel.
// Optional macro SPRITE_FLASH_EN compiles in the per-sprite frame-counted hit-flash blink.
module sprite_compositor #(
    parameter int          NUM_SPRITES   = 4,
    parameter int          FLASH_FRAMES  = 48,
    parameter int          TILE_Y_OFFSET = 35,
    parameter logic [11:0] BG_COLOR      = 12'hFFF,
    parameter logic [11:0] FG_COLOR      = 12'h00F,
    parameter logic [11:0] SLAB_COLOR    = 12'h0F0,
    localparam int         IDW           = $clog2(NUM_SPRITES) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frameStart,
    input  logic                      bright,
    input  logic [9:0]                hCount,
    input  logic [9:0]                vCount,
    input  logic [20*NUM_SPRITES-1:0] spritePos,
    input  logic [12*NUM_SPRITES-1:0] spriteDim,
    input  logic [12*NUM_SPRITES-1:0] spriteColor,
    input  logic [NUM_SPRITES-1:0]    spriteEn,
    input  logic [NUM_SPRITES-1:0]    spriteFlash,
    input  logic [2:0]                blockType,
    output logic [11:0]               rgb,
    output logic [IDW-1:0]            hitId
);

    localparam logic [IDW-1:0] NO_HIT = {1'b1, {(IDW-1){1'b0}}};

    logic [NUM_SPRITES-1:0][19:0] shPos;
    logic [NUM_SPRITES-1:0][11:0] shDim;
    logic [NUM_SPRITES-1:0][11:0] shColor;
    logic [NUM_SPRITES-1:0]       shEn;
    logic [NUM_SPRITES-1:0]       visible;
    logic [NUM_SPRITES-1:0]       hitVec;
    logic [NUM_SPRITES-1:0]       hitQ;
    logic                         brightQ;
    logic [2:0]                   blockTypeQ;
    logic                         slabRowQ;
    logic [4:0]                   vPhase;
    logic [11:0]                  rgbNext;
    logic [IDW-1:0]               hitIdNext;

    // Sprite attributes are frozen per frame so game logic can update them at any time.
    always_ff @(posedge clk) begin
        if (rst) begin
            shPos   <= '0;
            shDim   <= '0;
            shColor <= '0;
            shEn    <= '0;
        end else if (frameStart) begin
            shPos   <= spritePos;
            shDim   <= spriteDim;
            shColor <= spriteColor;
            shEn    <= spriteEn;
        end
    end

`ifdef SPRITE_FLASH_EN
    logic [NUM_SPRITES-1:0][7:0] flashCnt;

    // A new flash pulse always restarts the blink, even on a frameStart cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            flashCnt <= '0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (spriteFlash[i])
                    flashCnt[i] <= 8'(FLASH_FRAMES);
                else if (frameStart && flashCnt[i] != 8'd0)
                    flashCnt[i] <= flashCnt[i] - 8'd1;
            end
        end
    end

    always_comb begin
        visible = '1;
        for (int i = 0; i < NUM_SPRITES; i++)
            visible[i] = !(flashCnt[i] != 8'd0 && flashCnt[i][2]);
    end
`else
    logic unusedFlash;
    assign unusedFlash = ^spriteFlash;
    assign visible     = '1;
`endif

    // Bounds are widened to 11 bits so sprites at the right/bottom edge clip instead of wrapping.
    always_comb begin
        logic [10:0] xLo;
        logic [10:0] xHi;
        logic [10:0] yBot;
        logic [10:0] vTop;
        hitVec = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            xLo  = {1'b0, shPos[i][19:10]};
            xHi  = xLo + {5'b0, shDim[i][11:6]};
            yBot = {1'b0, shPos[i][9:0]};
            vTop = {1'b0, vCount} + {5'b0, shDim[i][5:0]};
            hitVec[i] = shEn[i] && visible[i] &&
                        ({1'b0, hCount} >= xLo) && ({1'b0, hCount} <= xHi) &&
                        ({1'b0, vCount} <= yBot) && (vTop >= yBot);
        end
    end

    assign vPhase = vCount[4:0] - 5'(TILE_Y_OFFSET);

    always_ff @(posedge clk) begin
        if (rst) begin
            hitQ       <= '0;
            brightQ    <= 1'b0;
            blockTypeQ <= '0;
            slabRowQ   <= 1'b0;
        end else begin
            hitQ       <= hitVec;
            brightQ    <= bright;
            blockTypeQ <= blockType;
            slabRowQ   <= (vPhase <= 5'd15);
        end
    end

    // Descending scan so the lowest-index hitting sprite is the last writer and wins.
    always_comb begin
        rgbNext   = BG_COLOR;
        hitIdNext = NO_HIT;
        if (!brightQ) begin
            rgbNext = 12'h000;
        end else if (|hitQ) begin
            for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
                if (hitQ[i]) begin
                    rgbNext   = shColor[i];
                    hitIdNext = IDW'(i);
                end
            end
        end else if (blockTypeQ == 3'd1) begin
            rgbNext = FG_COLOR;
        end else if (blockTypeQ == 3'd2 && slabRowQ) begin
            rgbNext = SLAB_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb   <= 12'h000;
            hitId <= NO_HIT;
        end else begin
            rgb   <= rgbNext;
            hitId <= hitIdNext;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed table-driven bench for sprite_compositor with hand sequences for shadowing, flash and reset.
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic        frameStart;
    logic        bright;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic [79:0] spritePos;
    logic [47:0] spriteDim;
    logic [47:0] spriteColor;
    logic [3:0]  spriteEn;
    logic [3:0]  spriteFlash;
    logic [2:0]  blockType;
    logic [11:0] rgb;
    logic [2:0]  hitId;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       name;
        logic        br;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [2:0]  bt;
        logic [11:0] expRgb;
        logic [2:0]  expHit;
    } vec_t;

    vec_t tabA[5];
    vec_t tabB[10];

    sprite_compositor dut (
        .clk(clk), .rst(rst), .frameStart(frameStart), .bright(bright),
        .hCount(hCount), .vCount(vCount), .spritePos(spritePos), .spriteDim(spriteDim),
        .spriteColor(spriteColor), .spriteEn(spriteEn), .spriteFlash(spriteFlash),
        .blockType(blockType), .rgb(rgb), .hitId(hitId)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [11:0] expRgb, input logic [2:0] expHit);
        logic ok;
        ok = (rgb === expRgb) && (hitId[2] === expHit[2]) && (expHit[2] || hitId === expHit);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL %s: rgb=%h hitId=%b, required rgb=%h hitId=%b", name, rgb, hitId, expRgb, expHit);
        end
    endtask

    // Present one pixel and sample its result two edges later.
    task automatic applyStimulus(input logic br, input logic [9:0] h, input logic [9:0] v, input logic [2:0] bt);
        bright    = br;
        hCount    = h;
        vCount    = v;
        blockType = bt;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic setSprite(input int idx, input int x, input int y, input int wm, input int hm,
                             input logic [11:0] color, input logic en);
        spritePos[20*idx +: 20]   = {10'(x), 10'(y)};
        spriteDim[12*idx +: 12]   = {6'(wm), 6'(hm)};
        spriteColor[12*idx +: 12] = color;
        spriteEn[idx]             = en;
    endtask

    task automatic pulseFrame(input logic [3:0] flash);
        frameStart  = 1'b1;
        spriteFlash = flash;
        @(posedge clk);
        #1;
        frameStart  = 1'b0;
        spriteFlash = '0;
    endtask

    initial begin
        int  cnt;
        bit  flashOn;
        logic [11:0] expC;
        logic [2:0]  expH;

        tabA[0] = '{"bgEmpty",   1'b1, 10'd50,  10'd100, 3'd0, 12'hFFF, 3'b100};
        tabA[1] = '{"slabTop",   1'b1, 10'd50,  10'd35,  3'd2, 12'h0F0, 3'b100};
        tabA[2] = '{"slabLower", 1'b1, 10'd50,  10'd51,  3'd2, 12'hFFF, 3'b100};
        tabA[3] = '{"fgBlock",   1'b1, 10'd50,  10'd51,  3'd1, 12'h00F, 3'b100};
        tabA[4] = '{"darkArea",  1'b0, 10'd50,  10'd35,  3'd1, 12'h000, 3'b100};

        tabB[0] = '{"spTopLeft",  1'b1, 10'd100,  10'd169, 3'd0, 12'hF00, 3'b000};
        tabB[1] = '{"spLeftOut",  1'b1, 10'd99,   10'd169, 3'd0, 12'hFFF, 3'b100};
        tabB[2] = '{"spAboveOut", 1'b1, 10'd100,  10'd168, 3'd0, 12'hFFF, 3'b100};
        tabB[3] = '{"spBotRight", 1'b1, 10'd131,  10'd200, 3'd0, 12'hF00, 3'b000};
        tabB[4] = '{"spRightOut", 1'b1, 10'd132,  10'd200, 3'd0, 12'hFFF, 3'b100};
        tabB[5] = '{"overlap",    1'b1, 10'd110,  10'd190, 3'd0, 12'hF00, 3'b000};
        tabB[6] = '{"edgeClip",   1'b1, 10'd1020, 10'd5,   3'd0, 12'h0A5, 3'b010};
        tabB[7] = '{"noWrap",     1'b1, 10'd10,   10'd5,   3'd0, 12'hFFF, 3'b100};
        tabB[8] = '{"spDark",     1'b0, 10'd100,  10'd169, 3'd0, 12'h000, 3'b100};
        tabB[9] = '{"spOverFg",   1'b1, 10'd100,  10'd169, 3'd1, 12'hF00, 3'b000};

`ifdef SPRITE_FLASH_EN
        flashOn = 1'b1;
`else
        flashOn = 1'b0;
`endif

        rst = 1'b1; frameStart = 1'b0; bright = 1'b1; hCount = '0; vCount = '0;
        spritePos = '0; spriteDim = '0; spriteColor = '0; spriteEn = '0; spriteFlash = '0;
        blockType = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetState", 12'h000, 3'b100);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("blackAfterReset", 12'h000, 3'b100);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(tabA[i].br, tabA[i].h, tabA[i].v, tabA[i].bt);
            checkOutput(tabA[i].name, tabA[i].expRgb, tabA[i].expHit);
        end

        setSprite(0, 100,  200, 31, 31, 12'hF00, 1'b1);
        setSprite(1, 105,  195, 15, 15, 12'h6DF, 1'b1);
        setSprite(2, 1000, 10,  63, 63, 12'h0A5, 1'b1);
        pulseFrame(4'b0000);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tabB[i].br, tabB[i].h, tabB[i].v, tabB[i].bt);
            checkOutput(tabB[i].name, tabB[i].expRgb, tabB[i].expHit);
        end

        spriteEn[0] = 1'b0;
        applyStimulus(1'b1, 10'd110, 10'd190, 3'd0);
        checkOutput("enHeldUntilFrame", 12'hF00, 3'b000);
        pulseFrame(4'b0000);
        applyStimulus(1'b1, 10'd110, 10'd190, 3'd0);
        checkOutput("sprite0Disabled", 12'h6DF, 3'b001);

        spriteEn[0] = 1'b1;
        pulseFrame(4'b0001);
        cnt = flashOn ? 48 : 0;
        for (int f = 0; f <= 50; f++) begin
            if (f > 0) begin
                pulseFrame(4'b0000);
                if (cnt != 0) cnt--;
            end
            applyStimulus(1'b1, 10'd100, 10'd169, 3'd0);
            if (cnt != 0 && cnt[2]) begin
                expC = 12'hFFF; expH = 3'b100;
            end else begin
                expC = 12'hF00; expH = 3'b000;
            end
            checkOutput($sformatf("flashFrame%0d", f), expC, expH);
        end

        setSprite(0, 300, 200, 31, 31, 12'hF00, 1'b1);
        applyStimulus(1'b1, 10'd100, 10'd169, 3'd0);
        checkOutput("posHeldMidFrame", 12'hF00, 3'b000);
        pulseFrame(4'b0000);
        applyStimulus(1'b1, 10'd100, 10'd169, 3'd0);
        checkOutput("posOldGone", 12'hFFF, 3'b100);
        applyStimulus(1'b1, 10'd300, 10'd169, 3'd0);
        checkOutput("posNew", 12'hF00, 3'b000);

        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midLineReset", 12'h000, 3'b100);
        rst = 1'b0;
        applyStimulus(1'b1, 10'd300, 10'd169, 3'd0);
        checkOutput("spritesGoneAfterRst", 12'hFFF, 3'b100);
        pulseFrame(4'b0000);
        applyStimulus(1'b1, 10'd300, 10'd169, 3'd0);
        checkOutput("spritesBackAfterFrame", 12'hF00, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
